// File: rtl/ide_disk_target.sv
// Simulated ATA PIO disk: task file, LBA28 READ/WRITE SECTORS, one-sector staging buffer
// and a synchronous word-RAM backing store addressed as {lba, word}.
module ide_disk_target #(
  parameter int LBA_BITS = 12,
  parameter bit SYNC_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  inout  wire  [15:0]           ide_data_bus,
  input  logic                  ide_dior,
  input  logic                  ide_diow,
  input  logic [1:0]            ide_cs,
  input  logic [2:0]            ide_da,
  output logic                  intrq,
  output logic [LBA_BITS+7:0]   mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata
);

  typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, RXFER = 3'd2, WXFER = 3'd3, FLUSH = 3'd4} state_t;

  state_t      state;
  logic [1:0]  dior_sync, diow_sync;
  logic        dior_q, diow_q, dior_s, diow_s;
  logic [7:0]  seccnt, lba0, lba1, lba2, drvhead, error;
  logic        err, nien, srst, irq_pending;
  logic [7:0]  ptr, pend_idx;
  logic [8:0]  cnt;
  logic        pend;
  logic [15:0] sbuf [256];
  logic [27:0] lba28, lba_next;
  logic        lba_oob, lba_next_oob, bsy, drq, dev;
  logic [7:0]  status;
  logic        tf_sel, ctl_sel, wr_tf, wr_ctl, rd_tf, data_wr, data_rd, sector_end, drive;
  logic [15:0] bus_in, rd_data, buf_wdata;
  logic        buf_we;
  logic [7:0]  buf_idx;

  assign dior_s       = SYNC_EN ? dior_sync[1] : ide_dior;
  assign diow_s       = SYNC_EN ? diow_sync[1] : ide_diow;
  assign bus_in       = ide_data_bus;
  assign lba28        = {drvhead[3:0], lba2, lba1, lba0};
  assign lba_next     = lba28 + 28'd1;
  assign lba_oob      = (lba28 >> LBA_BITS) != 28'd0;
  assign lba_next_oob = (lba_next >> LBA_BITS) != 28'd0;
  assign dev          = drvhead[4];
  assign tf_sel       = (ide_cs == 2'b10);
  assign ctl_sel      = (ide_cs == 2'b01) && (ide_da == 3'b110);
  assign bsy          = srst || (state == FETCH) || (state == FLUSH);
  assign drq          = (state == RXFER) || (state == WXFER);
  assign status       = {bsy, 1'b1, 1'b0, 1'b1, drq, 2'b00, err};
  // Side effects happen on the deasserting (rising) strobe edge, seen after synchronisation.
  assign wr_tf        = diow_s && !diow_q && tf_sel;
  assign wr_ctl       = diow_s && !diow_q && ctl_sel;
  assign rd_tf        = dior_s && !dior_q && tf_sel && !dev;
  assign data_wr      = wr_tf && (ide_da == 3'd0) && !dev && (state == WXFER);
  assign data_rd      = rd_tf && (ide_da == 3'd0) && (state == RXFER);
  assign sector_end   = (data_rd && (ptr == 8'hFF)) || ((state == FLUSH) && cnt[8]);
  assign drive        = !ide_dior && !dev && (tf_sel || ctl_sel);
  assign ide_data_bus = drive ? rd_data : 16'hzzzz;

  // Host read data mux
  always_comb begin
    rd_data = 16'hFFFF;
    if (ctl_sel) begin
      rd_data = {8'h00, status};
    end else begin
      case (ide_da)
        3'd0:    rd_data = (state == RXFER) ? sbuf[ptr] : 16'hFFFF;
        3'd1:    rd_data = {8'h00, error};
        3'd2:    rd_data = {8'h00, seccnt};
        3'd3:    rd_data = {8'h00, lba0};
        3'd4:    rd_data = {8'h00, lba1};
        3'd5:    rd_data = {8'h00, lba2};
        3'd6:    rd_data = {8'h00, drvhead};
        3'd7:    rd_data = {8'h00, status};
        default: rd_data = 16'hFFFF;
      endcase
    end
  end

  // Staging buffer write source: RAM fill during FETCH, host data during WXFER
  always_comb begin
    buf_we    = 1'b0;
    buf_idx   = pend_idx;
    buf_wdata = mem_rdata;
    if ((state == FETCH) && pend) begin
      buf_we = 1'b1;
    end else if (data_wr) begin
      buf_we    = 1'b1;
      buf_idx   = ptr;
      buf_wdata = bus_in;
    end else begin
      buf_we = 1'b0;
    end
  end

  // Staging buffer storage
  always_ff @(posedge clk) begin
    if (buf_we) sbuf[buf_idx] <= buf_wdata;
  end

  // Strobe synchronisers and edge-detect history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dior_sync <= 2'b11;
      diow_sync <= 2'b11;
      dior_q    <= 1'b1;
      diow_q    <= 1'b1;
    end else begin
      dior_sync <= {dior_sync[0], ide_dior};
      diow_sync <= {diow_sync[0], ide_diow};
      dior_q    <= dior_s;
      diow_q    <= diow_s;
    end
  end

  // Task file, command FSM and backing-store port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;  seccnt <= 8'd1;  lba0 <= 8'd1;  lba1 <= 8'd0;  lba2 <= 8'd0;
      drvhead <= 8'd0;  error <= 8'h01;  err <= 1'b0;  nien <= 1'b0;  srst <= 1'b0;
      irq_pending <= 1'b0;  intrq <= 1'b0;  mem_rd <= 1'b0;  mem_wr <= 1'b0;
      mem_addr <= {(LBA_BITS+8){1'b0}};  mem_wdata <= 16'h0000;
      ptr <= 8'd0;  cnt <= 9'd0;  pend <= 1'b0;  pend_idx <= 8'd0;
    end else begin
      pend     <= mem_rd;
      pend_idx <= mem_addr[7:0];
      intrq    <= irq_pending && !nien;
      if (wr_ctl) begin
        nien <= bus_in[1];
        srst <= bus_in[2];
      end
      if (srst) begin
        state <= IDLE;  seccnt <= 8'd1;  lba0 <= 8'd1;  lba1 <= 8'd0;  lba2 <= 8'd0;
        drvhead <= 8'd0;  error <= 8'h01;  err <= 1'b0;  irq_pending <= 1'b0;
        mem_rd <= 1'b0;  mem_wr <= 1'b0;  ptr <= 8'd0;  cnt <= 9'd0;
      end else begin
        if (rd_tf && (ide_da == 3'd7)) irq_pending <= 1'b0;
        if (wr_tf && !bsy) begin
          case (ide_da)
            3'd2:    seccnt  <= bus_in[7:0];
            3'd3:    lba0    <= bus_in[7:0];
            3'd4:    lba1    <= bus_in[7:0];
            3'd5:    lba2    <= bus_in[7:0];
            3'd6:    drvhead <= bus_in[7:0];
            default: ;
          endcase
        end
        case (state)
          IDLE: begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            if (wr_tf && (ide_da == 3'd7) && !dev) begin
              err <= 1'b0;  error <= 8'h00;  irq_pending <= 1'b0;
              if (!drvhead[6] || ((bus_in[7:0] != 8'h20) && (bus_in[7:0] != 8'h30))) begin
                err <= 1'b1;  error <= 8'h04;  irq_pending <= 1'b1;
              end else if (lba_oob) begin
                err <= 1'b1;  error <= 8'h10;  irq_pending <= 1'b1;
              end else if (bus_in[7:0] == 8'h20) begin
                state <= FETCH;  cnt <= 9'd0;
              end else begin
                state <= WXFER;  ptr <= 8'd0;
              end
            end
          end
          FETCH: begin
            if (!cnt[8]) begin
              mem_rd   <= 1'b1;
              mem_addr <= {lba28[LBA_BITS-1:0], cnt[7:0]};
              cnt      <= cnt + 9'd1;
            end else begin
              mem_rd <= 1'b0;
            end
            // Last fill word lands two edges after its request was issued
            if (pend && (pend_idx == 8'hFF)) begin
              state <= RXFER;  ptr <= 8'd0;  irq_pending <= 1'b1;
            end
          end
          RXFER: if (data_rd) ptr <= ptr + 8'd1;
          WXFER: begin
            if (data_wr) begin
              ptr <= ptr + 8'd1;
              if (ptr == 8'hFF) begin
                state <= FLUSH;  cnt <= 9'd0;
              end
            end
          end
          FLUSH: begin
            if (!cnt[8]) begin
              mem_wr    <= 1'b1;
              mem_addr  <= {lba28[LBA_BITS-1:0], cnt[7:0]};
              mem_wdata <= sbuf[cnt[7:0]];
              cnt       <= cnt + 9'd1;
            end else begin
              mem_wr <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
        if (sector_end) begin
          seccnt <= seccnt - 8'd1;
          {drvhead[3:0], lba2, lba1, lba0} <= lba_next;
          if (state == FLUSH) irq_pending <= 1'b1;
          if (seccnt == 8'd1) begin
            state <= IDLE;
          end else if (lba_next_oob) begin
            state <= IDLE;  err <= 1'b1;  error <= 8'h10;  irq_pending <= 1'b1;
          end else begin
            state <= (state == RXFER) ? FETCH : WXFER;
            cnt   <= 9'd0;
            ptr   <= 8'd0;
          end
        end
      end
    end
  end

endmodule
